shift_sequencer: RTL and testbench

- Multi-cycle 32-bit shift unit for the processor ALU. It applies one fixed power-of-two stage per cycle (16, 8, 4, 2, 1) to build any SLL or SRA by 0–31.
- It sequences the fixed-shift stages already in the processor instead of a full combinational barrel shifter, trading latency for area.
- It sits behind the ALU shift opcodes, with a valid/ready handshake on each side.

---
 rtl/shift_sequencer_pkg.sv | 36 +++
 rtl/shift_sequencer_stage_mux.sv | 30 +++
 rtl/shift_sequencer.sv | 121 ++++++++++++
 tb/tb_shift_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
package shift_sequencer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned STG_W   = 3;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  // Index of the x16 stage; stages count down to 0 (x1).
  localparam logic [STG_W-1:0] STAGE_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One shift request as presented on the input handshake.
  typedef struct packed {
    logic                 op;
    logic [SHAMT_W-1:0]   shamt;
    logic [DATA_W-1:0]    data;
  } shift_req_t;

  // Stage index of the most significant set bit (0 when none is set).
  function automatic logic [STG_W-1:0] top_bit(input logic [SHAMT_W-1:0] v);
    if (v[4])      return 3'd4;
    else if (v[3]) return 3'd3;
    else if (v[2]) return 3'd2;
    else if (v[1]) return 3'd1;
    else           return 3'd0;
  endfunction

endpackage

// File: rtl/shift_sequencer_stage_mux.sv
// Selects one fixed power-of-two SLL/SRA stage, or passes the value through.
module shift_stage_mux
  import shift_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  logic              op,
  input  logic [STG_W-1:0]  stage,
  input  logic              enable,
  output logic [DATA_W-1:0] result_c
);

  logic sgn;
  assign sgn = acc[DATA_W-1];

  // Fixed-distance stage select; SRA replicates bit 31, SLL fills zeros.
  always_comb begin
    result_c = acc;
    if (enable) begin
      case (stage)
        3'd4: result_c = (op == OP_SRA) ? {{16{sgn}}, acc[31:16]} : {acc[15:0], 16'd0};
        3'd3: result_c = (op == OP_SRA) ? {{8{sgn}},  acc[31:8]}  : {acc[23:0], 8'd0};
        3'd2: result_c = (op == OP_SRA) ? {{4{sgn}},  acc[31:4]}  : {acc[27:0], 4'd0};
        3'd1: result_c = (op == OP_SRA) ? {{2{sgn}},  acc[31:2]}  : {acc[29:0], 2'd0};
        3'd0: result_c = (op == OP_SRA) ? {sgn,       acc[31:1]}  : {acc[30:0], 1'b0};
        default: result_c = acc;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit SLL/SRA built from sequenced fixed power-of-two stages.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_op,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy
);

  state_t             state, state_n;
  logic [DATA_W-1:0]  acc, acc_n;
  logic [SHAMT_W-1:0] rem, rem_n;
  logic               op, op_n;
  logic [STG_W-1:0]   stg, stg_n;

  logic               in_ready_n, out_valid_n, busy_n;
  logic [DATA_W-1:0]  out_data_n;

  shift_req_t         req;
  logic [STG_W-1:0]   stage_sel;
  logic               stage_en;
  logic [DATA_W-1:0]  shifted;

  assign req = '{op: in_op, shamt: in_shamt, data: in_data};

  // Skip mode walks set bits from the top; fixed mode walks every stage.
  assign stage_sel = SKIP_ZERO ? top_bit(rem) : stg;
  assign stage_en  = SKIP_ZERO ? 1'b1 : rem[stg];

  shift_stage_mux u_stage_mux (
    .acc      (acc),
    .op       (op),
    .stage    (stage_sel),
    .enable   (stage_en),
    .result_c (shifted)
  );

  // State and datapath registers plus registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      rem       <= '0;
      op        <= OP_SLL;
      stg       <= STAGE_MAX;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      rem       <= rem_n;
      op        <= op_n;
      stg       <= stg_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      busy      <= busy_n;
    end
  end

  // Next-state, datapath update and next output values.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    rem_n   = rem;
    op_n    = op;
    stg_n   = stg;

    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          acc_n   = req.data;
          rem_n   = req.shamt;
          op_n    = req.op;
          stg_n   = STAGE_MAX;
          state_n = (SKIP_ZERO && (req.shamt == '0)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_n = ST_IDLE;
        end else if (SKIP_ZERO) begin
          acc_n = shifted;
          rem_n[stage_sel] = 1'b0;
          if (rem_n == '0) state_n = ST_DONE;
        end else begin
          acc_n = shifted;
          if (stg == '0) begin
            stg_n   = STAGE_MAX;
            state_n = ST_DONE;
          end else begin
            stg_n = stg - 3'd1;
          end
        end
      end
      ST_DONE: begin
        if (flush || out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    in_ready_n  = (state_n == ST_IDLE);
    busy_n      = (state_n != ST_IDLE);
    out_valid_n = (state_n == ST_DONE);
    out_data_n  = (state_n == ST_DONE) ? acc_n : '0;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: both SKIP_ZERO settings against a latency/result model.
module tb_shift_sequencer;

  logic        clock;
  logic        reset_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic [4:0]  in_shamt  [2];
  logic        in_op     [2];
  logic        flush     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic        busy      [2];

  int checks   = 0;
  int failures = 0;

  // Instance 0 skips zero stages, instance 1 always runs all five.
  shift_sequencer #(.SKIP_ZERO(1'b1)) u_skip (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_shamt(in_shamt[0]), .in_op(in_op[0]), .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );

  shift_sequencer #(.SKIP_ZERO(1'b0)) u_fixed (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_shamt(in_shamt[1]), .in_op(in_op[1]), .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the arithmetic definition of SLL / SRA.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh, input logic op);
    if (op) return 32'($signed(d) >>> sh);
    return d << sh;
  endfunction

  function automatic int ref_latency(input int idx, input logic [4:0] sh);
    if (idx == 0) return $countones(sh) + 1;
    return 6;
  endfunction

  // Cycle-level model: after accept, the result appears once the latency budget elapses.
  logic        m_busy [2] = '{1'b0, 1'b0};
  logic        m_done [2] = '{1'b0, 1'b0};
  logic        m_rdy  [2] = '{1'b0, 1'b0};
  int          m_cnt  [2] = '{0, 0};
  logic [31:0] m_res  [2] = '{32'd0, 32'd0};

  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_rdy[i]  <= 1'b0;
        m_cnt[i]  <= 0;
        m_res[i]  <= '0;
      end else if (m_done[i]) begin
        if (flush[i] || out_ready[i]) begin
          m_done[i] <= 1'b0;
          m_busy[i] <= 1'b0;
          m_rdy[i]  <= 1'b1;
        end
      end else if (m_busy[i]) begin
        if (flush[i]) begin
          m_busy[i] <= 1'b0;
          m_rdy[i]  <= 1'b1;
        end else begin
          if (m_cnt[i] == 1) m_done[i] <= 1'b1;
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end else begin
        m_rdy[i] <= 1'b1;
        if (in_valid[i] && m_rdy[i]) begin
          m_busy[i] <= 1'b1;
          m_rdy[i]  <= 1'b0;
          m_res[i]  <= ref_shift(in_data[i], in_shamt[i], in_op[i]);
          m_cnt[i]  <= ref_latency(i, in_shamt[i]) - 1;
          if (ref_latency(i, in_shamt[i]) == 1) m_done[i] <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs of both instances against the model.
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cyc%0d.in_ready", i),  32'(in_ready[i]),  32'(m_rdy[i]));
      check($sformatf("cyc%0d.busy", i),      32'(busy[i]),      32'(m_busy[i]));
      check($sformatf("cyc%0d.out_valid", i), 32'(out_valid[i]), 32'(m_done[i]));
      check($sformatf("cyc%0d.out_data", i),  out_data[i],       m_done[i] ? m_res[i] : 32'd0);
    end
  end

  // Issue one op, measure latency, optionally stall/poke, then handshake.
  task automatic run_op(input int idx, input logic [31:0] d, input logic [4:0] sh, input logic op,
                        input logic [31:0] exp_data, input int exp_lat, input int hold,
                        input bit poke, input bit fl);
    int lat;
    @(negedge clock);
    in_data[idx]  = d;
    in_shamt[idx] = sh;
    in_op[idx]    = op;
    in_valid[idx] = 1'b1;
    flush[idx]    = fl;
    @(posedge clock);
    #2;
    in_valid[idx] = 1'b0;
    flush[idx]    = 1'b0;
    check($sformatf("op%0d.busy_after_accept", idx), 32'(busy[idx]), 32'd1);
    lat = 1;
    while (!out_valid[idx] && lat < 20) begin
      @(posedge clock);
      #2;
      lat++;
    end
    check($sformatf("op%0d.latency", idx), 32'(lat), 32'(exp_lat));
    check($sformatf("op%0d.result", idx), out_data[idx], exp_data);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_data[idx]  = 32'hDEAD_BEEF;
        in_shamt[idx] = 5'd1;
        in_valid[idx] = 1'b1;
      end
      @(posedge clock);
      #2;
      check($sformatf("op%0d.stall_data", idx), out_data[idx], exp_data);
      check($sformatf("op%0d.stall_in_ready", idx), 32'(in_ready[idx]), 32'd0);
    end
    @(negedge clock);
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    @(posedge clock);
    #2;
    out_ready[idx] = 1'b0;
    check($sformatf("op%0d.valid_cleared", idx), 32'(out_valid[idx]), 32'd0);
    check($sformatf("op%0d.ready_after", idx), 32'(in_ready[idx]), 32'd1);
    check($sformatf("op%0d.idle_after", idx), 32'(busy[idx]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; in_shamt[i] = '0; in_op[i] = 1'b0;
      flush[i] = 1'b0; out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clock);
    check("reset.in_ready", 32'(in_ready[0]), 32'd0);
    check("reset.out_data", out_data[0], 32'd0);
    reset_n = 1'b1;
    #1;
    check("release.in_ready_low", 32'(in_ready[1]), 32'd0);
    @(posedge clock);
    #2;
    check("release.in_ready_high", 32'(in_ready[0]), 32'd1);

    // Sign fill on a single x16 stage
    run_op(0, 32'h8000_0000, 5'd16, 1'b1, 32'hFFFF_8000, 2, 0, 1'b0, 1'b0);
    run_op(1, 32'h8000_0000, 5'd16, 1'b1, 32'hFFFF_8000, 6, 0, 1'b0, 1'b0);
    // Every stage used
    run_op(0, 32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 6, 0, 1'b0, 1'b0);
    run_op(1, 32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 6, 0, 1'b0, 1'b0);
    // Zero shift amount
    run_op(0, 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 1, 0, 1'b0, 1'b0);
    run_op(1, 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 6, 0, 1'b0, 1'b0);
    // Stall with a dropped request during DONE
    run_op(0, 32'h7FFF_FFFF, 5'd5, 1'b1, 32'h03FF_FFFF, 3, 4, 1'b1, 1'b0);
    // Full sign spread and SLL of all-ones
    run_op(0, 32'hF000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 6, 0, 1'b0, 1'b0);
    run_op(0, 32'hFFFF_FFFF, 5'd4, 1'b0, 32'hFFFF_FFF0, 2, 0, 1'b0, 1'b0);
    run_op(1, 32'hFFFF_FFFF, 5'd4, 1'b0, 32'hFFFF_FFF0, 6, 2, 1'b0, 1'b0);
    // Flush while IDLE does not block the accept
    run_op(0, 32'h0000_00F0, 5'd3, 1'b0, 32'h0000_0780, 3, 0, 1'b0, 1'b1);

    // Flush in the second SHIFT cycle discards the op
    @(negedge clock);
    in_data[0] = 32'h0000_0001; in_shamt[0] = 5'd31; in_op[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clock);
    #2;
    in_valid[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    flush[0] = 1'b1;
    @(posedge clock);
    #2;
    flush[0] = 1'b0;
    check("flush.in_ready", 32'(in_ready[0]), 32'd1);
    check("flush.busy", 32'(busy[0]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #2;
      check("flush.no_valid", 32'(out_valid[0]), 32'd0);
    end

    // Asynchronous reset in the middle of SHIFT
    @(negedge clock);
    in_data[1] = 32'h0000_0003; in_shamt[1] = 5'd7; in_op[1] = 1'b0; in_valid[1] = 1'b1;
    @(posedge clock);
    #2;
    in_valid[1] = 1'b0;
    @(posedge clock);
    #3;
    check("areset.pre_busy", 32'(busy[1]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("areset.busy", 32'(busy[1]), 32'd0);
    check("areset.out_valid", 32'(out_valid[1]), 32'd0);
    check("areset.in_ready", 32'(in_ready[1]), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #2;
    check("areset.ready_again", 32'(in_ready[1]), 32'd1);
    run_op(1, 32'h0000_0003, 5'd7, 1'b0, 32'h0000_0180, 6, 0, 1'b0, 1'b0);
    run_op(0, 32'h8765_4321, 5'd9, 1'b1, 32'hFFC3_B2A1, 3, 1, 1'b0, 1'b0);

    repeat (2) @(posedge clock);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
